// File: rtl/pwm_dac_pkg.sv
// pwm_dac_pkg: shared types and constants for the PWM DAC output stage.
package pwm_dac_pkg;

   // Default sample / duty / PWM counter width
   localparam int DEFAULT_WIDTH = 8;

   // Amplitude scaling: amp is 4 bits, product is shifted right by 4
   localparam int AMP_W     = 4;
   localparam int AMP_SHIFT = 4;

   // Output stage FSM
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pwm_state_t;

endpackage

// File: rtl/pwm_dac_if.sv
// pwm_dac_if: sample path between the DDS (master) and the PWM DAC (slave).
//
// Handshake: sample_valid is a single-cycle strobe qualifying sample_in; there
// is no ready -- the slave always accepts and a write over an unused sample is
// flagged as overrun. sample_req is a 1-cycle pulse from the slave meaning
// "the buffered sample was just consumed, send the next one".
interface pwm_dac_if
   import pwm_dac_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic [WIDTH-1:0] sample_in;
   logic             sample_valid;
   logic             sample_req;

   modport master (output sample_in, output sample_valid, input sample_req);
   modport slave  (input sample_in, input sample_valid, output sample_req);

endinterface

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: prescaler producing a 1-clk tick every PRESCALE clocks while
// enabled. The count is held at zero when disabled so every run starts aligned.
module pwm_tick_gen #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] pcnt;

   // Prescale counter: wraps at PRESCALE-1, cleared while disabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt <= '0;
      end else if (!en || pcnt == LAST) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + CW'(1);
      end
   end

   // With PRESCALE=1 LAST is 0, so tick simply follows en
   assign tick = en && (pcnt == LAST);

endmodule

// File: rtl/pwm_dac_out.sv
// pwm_dac_out: PWM output stage for DDS samples. One sample is double-buffered
// (pend -> duty); a new one is requested at every PWM period boundary.
// Optional build macro PWM_AMP_SCALE_EN adds amp[3:0] scaling of loaded duty.
module pwm_dac_out
   import pwm_dac_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr_flags,
`ifdef PWM_AMP_SCALE_EN
   input  logic [AMP_W-1:0] amp,
`endif
   pwm_dac_if.slave         bus,
   output logic             pwm_out,
   output logic             busy,
   output logic             overrun,
   output logic             underrun,
   output pwm_state_t       dbg_state
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   pwm_state_t       state_q, state_d;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] duty_q;
   logic [WIDTH-1:0] pend_q;
   logic             pend_full_q;
   logic [WIDTH-1:0] load_val;
   logic             tick;
   logic             consume;
   logic             req;
   logic             ovr_set;
   logic             und_set;

   pwm_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == RUN),
      .tick (tick)
   );

`ifdef PWM_AMP_SCALE_EN
   // amp+1 ranges 1..16, so amp=15 is unity gain after the shift
   logic [WIDTH+AMP_W-1:0] prod;
   logic [AMP_W:0]         amp_p1;
   assign amp_p1   = {1'b0, amp} + (AMP_W+1)'(1);
   assign prod     = (WIDTH+AMP_W)'(pend_q) * (WIDTH+AMP_W)'(amp_p1);
   assign load_val = prod[AMP_SHIFT +: WIDTH];
`else
   assign load_val = pend_q;
`endif

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus the consume / request / flag-set decisions
   always_comb begin
      state_d = state_q;
      consume = 1'b0;
      req     = 1'b0;
      und_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && pend_full_q) begin
               state_d = RUN;
               consume = 1'b1;
               req     = 1'b1;
            end
         end
         RUN: begin
            // Period boundary: en is only looked at here, so a period always completes
            if (tick && cnt_q == CNT_MAX) begin
               if (en) begin
                  req = 1'b1;
                  if (pend_full_q) begin
                     consume = 1'b1;
                  end else begin
                     und_set = 1'b1;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Writing in the consume cycle hands the old sample to duty, so it is not lost
      ovr_set = bus.sample_valid && pend_full_q && !consume;
   end

   // PWM counter, duty register and pending-sample buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         duty_q      <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
      end else begin
         if (state_q == RUN) begin
            if (tick) begin
               cnt_q <= cnt_q + WIDTH'(1);
            end
         end else begin
            cnt_q <= '0;
         end
         if (consume) begin
            duty_q <= load_val;
         end
         if (bus.sample_valid) begin
            pend_q      <= bus.sample_in;
            pend_full_q <= 1'b1;
         end else if (consume) begin
            pend_full_q <= 1'b0;
         end
      end
   end

   // Registered PWM compare and sticky flags (a set event beats clr_flags)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_out  <= 1'b0;
         overrun  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         pwm_out  <= (state_q == RUN) && (cnt_q < duty_q);
         overrun  <= ovr_set || (overrun && !clr_flags);
         underrun <= und_set || (underrun && !clr_flags);
      end
   end

   assign bus.sample_req = req;
   assign busy           = (state_q == RUN);
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_pwm_dac_out.sv
// tb_pwm_dac_out: scoreboard bench for pwm_dac_out (WIDTH=8, PRESCALE=1).
// Expected high-time per PWM period is queued when the sample is driven and
// popped when the monitor sees that period finish on pwm_out.
`timescale 1ns/1ps
module tb_pwm_dac_out;
   import pwm_dac_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       en = 1'b0;
   logic       clr_flags = 1'b0;
   logic       pwm_out, busy, overrun, underrun;
   pwm_state_t dbg_state;
`ifdef PWM_AMP_SCALE_EN
   logic [3:0] amp = 4'd15;
`endif

   pwm_dac_if #(.WIDTH(8)) bus ();

   int unsigned n_vec = 0;
   int unsigned n_miss = 0;
   int unsigned cyc = 0;
   int unsigned n_req = 0;
   int unsigned t_req = 0;
   int unsigned t_prev = 0;
   int unsigned acc = 0;
   bit          armed = 1'b0;
   bit          req_d1 = 1'b0;
   bit          busy_d1 = 1'b0;
   logic [7:0]  exp_q[$];

   pwm_dac_out #(.WIDTH(8), .PRESCALE(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .clr_flags (clr_flags),
`ifdef PWM_AMP_SCALE_EN
      .amp       (amp),
`endif
      .bus       (bus),
      .pwm_out   (pwm_out),
      .busy      (busy),
      .overrun   (overrun),
      .underrun  (underrun),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checker ----------------
   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   function automatic logic [7:0] scaled(input logic [7:0] v);
`ifdef PWM_AMP_SCALE_EN
      int unsigned p;
      p = int'(v) * (int'(amp) + 1);
      return 8'(p >> 4);
`else
      return v;
`endif
   endfunction

   task automatic expect_duty(input logic [7:0] v);
      exp_q.push_back(scaled(v));
   endtask

   task automatic supply(input logic [7:0] v);
      @(posedge clk); #1;
      bus.sample_in    = v;
      bus.sample_valid = 1'b1;
      @(posedge clk); #1;
      bus.sample_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 clr_flags = 1'b1;
      @(posedge clk); #1 clr_flags = 1'b0;
   endtask

   // Returns at the negedge of the next sample_req cycle
   task automatic wait_req();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.sample_req && n < 600);
      if (!bus.sample_req) chk("req_timeout", 0, 1);
      t_prev = t_req;
      t_req  = cyc;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 600);
   endtask

   // ---------------- scoreboard monitor ----------------
   // A period's pwm_out samples run from 2 cycles after its load request up to
   // 1 cycle after the next request (or the first cycle busy is low).
   always @(negedge clk) begin
      if (rst) begin
         armed = 1'b0;
         acc   = 0;
      end else begin
         if (bus.sample_req) n_req++;
         if (armed) acc += int'(pwm_out);
         if (req_d1 || (busy_d1 && !busy)) begin
            if (armed) begin
               if (exp_q.size() == 0) chk("sb_empty", 0, 1);
               else chk("period_high", acc, int'(exp_q.pop_front()));
            end
            armed = req_d1;
            acc   = 0;
         end
      end
      req_d1  = bus.sample_req && !rst;
      busy_d1 = busy;
   end

   // ---------------- stimulus ----------------
   initial begin
      int unsigned t_f;
      int unsigned snap;
      rst = 1'b1;
      bus.sample_in    = '0;
      bus.sample_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pwm", pwm_out, 0);
      chk("rst_req", bus.sample_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_und", underrun, 0);
      chk("rst_state", dbg_state, IDLE);
      rst = 1'b0;

      // 1: first sample, start, 128/256 duty
      supply(8'h80); expect_duty(8'h80);
      @(posedge clk); #1 en = 1'b1;
      wait_req();
      chk("busy_before_run", busy, 0);
      @(negedge clk);
      chk("busy_run", busy, 1);

      // 2: duty 0x00 then 0xFF twice
      supply(8'h00); expect_duty(8'h00);
      wait_req();
      supply(8'hFF); expect_duty(8'hFF);
      wait_req();
      chk("req_gap", t_req - t_prev, 256);
      supply(8'hFF); expect_duty(8'hFF);
      wait_req();
      chk("req_gap", t_req - t_prev, 256);

      // 3: two writes in one period -> overrun, second wins
      supply(8'h10);
      supply(8'h20); expect_duty(8'h20);
      @(negedge clk);
      chk("overrun_set", overrun, 1);
      chk("underrun_clear", underrun, 0);
      pulse_clr();
      @(negedge clk);
      chk("overrun_clr", overrun, 0);
      wait_req();

      // 4: no sample -> underrun, duty repeats
      expect_duty(8'h20);
      wait_req();
      @(negedge clk);
      chk("underrun_set", underrun, 1);
      pulse_clr();
      @(negedge clk);
      chk("underrun_clr", underrun, 0);

      // 5: write in the boundary cycle with pend full
      supply(8'h30); expect_duty(8'h30);
      do begin @(posedge clk); #1; end while (cyc != t_req + 256);
      bus.sample_in    = 8'h40;
      bus.sample_valid = 1'b1;
      @(negedge clk);
      chk("req_at_boundary", bus.sample_req, 1);
      @(posedge clk); #1 bus.sample_valid = 1'b0;
      expect_duty(8'h40);
      @(negedge clk);
      chk("no_overrun_on_consume", overrun, 0);
      wait_req();
      supply(8'h50); expect_duty(8'h50);
      wait_req();
      t_f = t_req;

      // 6: en drop mid-period -> period completes, then IDLE
      supply(8'h60);
      snap = n_req;
      repeat (100) @(posedge clk);
      #1 en = 1'b0;
      wait_idle();
      chk("idle_after_period", cyc - t_f, 257);
      chk("req_during_drop", n_req - snap, 0);
      @(negedge clk);
      chk("idle_pwm", pwm_out, 0);
      chk("idle_busy", busy, 0);
      chk("idle_state", dbg_state, IDLE);

      // restart from kept pend, then async reset mid-period
      expect_duty(8'h60);
      @(posedge clk); #1 en = 1'b1;
      wait_req();
      supply(8'h11);
      supply(8'h22);
      @(negedge clk);
      chk("overrun_pre_rst", overrun, 1);
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("pwm_hi_pre_rst", pwm_out, 1);
      @(posedge clk); #3 rst = 1'b1;
      #1;
      chk("arst_pwm", pwm_out, 0);
      chk("arst_busy", busy, 0);
      chk("arst_req", bus.sample_req, 0);
      chk("arst_ovr", overrun, 0);
      chk("arst_und", underrun, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      snap = n_req;
      repeat (30) @(negedge clk);
      chk("no_req_after_rst", n_req - snap, 0);
      chk("idle_after_rst", busy, 0);

      // restart; amp changes after load do not touch the running period
`ifdef PWM_AMP_SCALE_EN
      amp = 4'd7;
`endif
      supply(8'h80); expect_duty(8'h80);
      wait_req();
      repeat (10) @(posedge clk);
`ifdef PWM_AMP_SCALE_EN
      #1 amp = 4'd15;
`endif
      supply(8'h02); expect_duty(8'h02);
      wait_req();
      @(posedge clk); #1 en = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
      chk("final_underrun", underrun, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
